// File: rtl/dac_spi_pkg.sv
// Shared types and frame layout for the dual-channel SPI DAC scheduler.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam int FRAME_BITS = 16;

  localparam int CH_BIT     = 15;
  localparam int BUF_BIT    = 14;
  localparam int GA_N_BIT   = 13;
  localparam int SHDN_N_BIT = 12;
  localparam int DATA_MSB   = 11;
  localparam int DATA_LSB   = 0;

endpackage

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 frame serializer: SCK divider, bit counter and MSB-first shift register.
module spi_tx_shifter
  import dac_spi_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sck,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  done
);

  localparam int DIV_W = $clog2(SCK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic                  active;
  logic [FRAME_BITS-1:0] shreg;
  logic [DIV_W-1:0]      div_cnt;
  logic [3:0]            bit_cnt;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      active  <= 1'b0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        active  <= 1'b1;
        cs_n    <= 1'b0;
        sck     <= 1'b0;
        mosi    <= frame[FRAME_BITS-1];
        shreg   <= {frame[FRAME_BITS-2:0], 1'b0};
        div_cnt <= DIV_LOAD;
        bit_cnt <= '0;
      end else if (active) begin
        if (div_cnt == '0) begin
          div_cnt <= DIV_LOAD;
          sck     <= ~sck;
          // Falling edge: either present the next bit or close the frame.
          if (sck) begin
            if (bit_cnt == LAST_BIT) begin
              active <= 1'b0;
              cs_n   <= 1'b1;
              done   <= 1'b1;
              mosi   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              mosi    <= shreg[FRAME_BITS-1];
              shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dac_spi_scheduler.sv
// Round-robin scheduler sharing one SPI DAC between two sample streams.
// Optional macro DAC_SPI_LDAC_EN adds spi_ldac_n, pulsed after channel-1 frames.
//   state | meaning
//   IDLE  | both channels ready, waiting for a valid sample
//   SHIFT | frame being serialized, CS low
//   GAP   | CS high inter-frame gap (and LDAC pulse when enabled)
module dac_spi_scheduler
  import dac_spi_pkg::*;
#(
  parameter int SCK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [11:0] ch0_data,
  input  logic        ch0_valid,
  output logic        ch0_ready,
  input  logic [11:0] ch1_data,
  input  logic        ch1_valid,
  output logic        ch1_ready,
  input  logic [2:0]  dac_cfg,
  output logic        spi_mosi,
  output logic        spi_sck,
  output logic        spi_cs,
  output logic        busy,
  output logic        frame_done
`ifdef DAC_SPI_LDAC_EN
  ,
  output logic        spi_ldac_n
`endif
);

  localparam int LDAC_LEN = 2 * SCK_DIV;
  localparam int GAP_MAX  = (CS_GAP > LDAC_LEN) ? CS_GAP : LDAC_LEN;
  localparam int GAP_W    = $clog2(GAP_MAX + 1) + 1;

  state_t                state, next_state;
  logic                  last, cur_ch, grant_ch, accept, shift_done;
  logic [GAP_W-1:0]      gap_len, gap_cnt;
  logic [FRAME_BITS-1:0] frame;

  always_comb begin
    grant_ch   = (ch0_valid && ch1_valid) ? ~last : ch1_valid;
    accept     = 1'b0;
    next_state = state;

    frame                      = '0;
    frame[CH_BIT]              = grant_ch;
    frame[BUF_BIT]             = dac_cfg[2];
    frame[GA_N_BIT]            = dac_cfg[1];
    frame[SHDN_N_BIT]          = dac_cfg[0];
    frame[DATA_MSB:DATA_LSB]   = grant_ch ? ch1_data : ch0_data;

`ifdef DAC_SPI_LDAC_EN
    gap_len = cur_ch ? GAP_W'(GAP_MAX) : GAP_W'(CS_GAP);
`else
    gap_len = GAP_W'(CS_GAP);
`endif

    case (state)
      IDLE: begin
        if (ch0_valid || ch1_valid) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      // The done cycle already counts as the first CS-high gap cycle.
      SHIFT: if (shift_done) next_state = (gap_len > GAP_W'(1)) ? GAP : IDLE;
      GAP:   if (gap_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      cur_ch  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        last   <= grant_ch;
        cur_ch <= grant_ch;
      end
      if (state == SHIFT && shift_done) begin
        gap_cnt <= gap_len - GAP_W'(2);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  assign ch0_ready  = (state == IDLE);
  assign ch1_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign frame_done = shift_done;

`ifdef DAC_SPI_LDAC_EN
  localparam int LDAC_W = $clog2(LDAC_LEN) + 1;
  logic [LDAC_W-1:0] ldac_cnt;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      ldac_cnt <= '0;
    end else if (shift_done && cur_ch) begin
      ldac_cnt <= LDAC_W'(LDAC_LEN - 1);
    end else if (ldac_cnt != '0) begin
      ldac_cnt <= ldac_cnt - LDAC_W'(1);
    end
  end

  // Low from the CS-rise cycle itself, then held by the counter.
  assign spi_ldac_n = ~((shift_done && cur_ch) || (ldac_cnt != '0));
`endif

  spi_tx_shifter #(
    .SCK_DIV(SCK_DIV)
  ) u_shifter (
    .sysclk (sysclk),
    .reset  (reset),
    .start  (accept),
    .frame  (frame),
    .sck    (spi_sck),
    .mosi   (spi_mosi),
    .cs_n   (spi_cs),
    .done   (shift_done)
  );

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Bench for dac_spi_scheduler: two instances (default timing and SCK_DIV=1/CS_GAP=1)
// driven with directed and random traffic, checked each cycle against a timing model.
module tb_dac_spi_scheduler;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        rst [2];
  logic [11:0] d0 [2];
  logic [11:0] d1 [2];
  logic        v0 [2];
  logic        v1 [2];
  logic [2:0]  cfg [2];
  logic        r0 [2];
  logic        r1 [2];
  logic        mosi [2];
  logic        sck [2];
  logic        cs [2];
  logic        busy [2];
  logic        done [2];
`ifdef DAC_SPI_LDAC_EN
  logic        ldac [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic wait_expired = 1'b0;

  // Reference model state, owned by the monitor.
  int          acc [2]    = '{0, 0};
  int          rdy_at [2] = '{0, 0};
  logic        acc_ok [2] = '{1'b0, 1'b0};
  logic        mlast [2]  = '{1'b1, 1'b1};
  logic        chn [2]    = '{1'b0, 1'b0};
  logic        post_rst [2] = '{1'b0, 1'b0};
  logic [15:0] fr [2]     = '{16'h0, 16'h0};
  int          take0 [2]  = '{0, 0};
  int          take1 [2]  = '{0, 0};
  int          hs [2]     = '{0, 0};

  // Stimulus control, owned by the main block.
  int   seen0 [2] = '{0, 0};
  int   seen1 [2] = '{0, 0};
  logic refresh = 1'b0, oneshot = 1'b0, rnd_cfg = 1'b0, rnd_valid = 1'b0, rnd_rst1 = 1'b0;

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int i, input logic g);
    int base;
    base = (i == 0) ? 2 : 1;
`ifdef DAC_SPI_LDAC_EN
    if (g && (2 * div_of(i) > base)) base = 2 * div_of(i);
`else
    if (g) base = base + 0;
`endif
    return base;
  endfunction

  task automatic check(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
    end
  endtask

  dac_spi_scheduler #(.SCK_DIV(4), .CS_GAP(2)) u_dut0 (
    .sysclk(sysclk), .reset(rst[0]),
    .ch0_data(d0[0]), .ch0_valid(v0[0]), .ch0_ready(r0[0]),
    .ch1_data(d1[0]), .ch1_valid(v1[0]), .ch1_ready(r1[0]),
    .dac_cfg(cfg[0]), .spi_mosi(mosi[0]), .spi_sck(sck[0]), .spi_cs(cs[0]),
    .busy(busy[0]), .frame_done(done[0])
`ifdef DAC_SPI_LDAC_EN
    , .spi_ldac_n(ldac[0])
`endif
  );

  dac_spi_scheduler #(.SCK_DIV(1), .CS_GAP(1)) u_dut1 (
    .sysclk(sysclk), .reset(rst[1]),
    .ch0_data(d0[1]), .ch0_valid(v0[1]), .ch0_ready(r0[1]),
    .ch1_data(d1[1]), .ch1_valid(v1[1]), .ch1_ready(r1[1]),
    .dac_cfg(cfg[1]), .spi_mosi(mosi[1]), .spi_sck(sck[1]), .spi_cs(cs[1]),
    .busy(busy[1]), .frame_done(done[1])
`ifdef DAC_SPI_LDAC_EN
    , .spi_ldac_n(ldac[1])
`endif
  );

  int   m_d, m_t;
  logic m_in, m_rdy, m_g;

  // Cycle k after an accept: CS low for k=1..32*DIV, SCK high on odd half-periods,
  // bit b on MOSI for 2*DIV cycles, done at k=1+32*DIV, ready gap cycles later.
  always @(negedge sysclk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      m_d   = div_of(i);
      m_t   = cyc - acc[i] - 1;
      m_in  = acc_ok[i] && (m_t >= 0) && (m_t < 32 * m_d);
      m_rdy = (cyc >= rdy_at[i]);
      check("spi_cs", i, 16'(cs[i]), 16'(!m_in));
      check("spi_sck", i, 16'(sck[i]), m_in ? 16'((m_t / m_d) % 2) : 16'(0));
      if (m_in) check("spi_mosi", i, 16'(mosi[i]), 16'(fr[i][15 - m_t / (2 * m_d)]));
      if (post_rst[i]) check("mosi_after_reset", i, 16'(mosi[i]), 16'(0));
      check("frame_done", i, 16'(done[i]), 16'(acc_ok[i] && (m_t == 32 * m_d)));
      check("ch0_ready", i, 16'(r0[i]), 16'(m_rdy));
      check("ch1_ready", i, 16'(r1[i]), 16'(m_rdy));
      check("busy", i, 16'(busy[i]), 16'(!m_rdy));
`ifdef DAC_SPI_LDAC_EN
      check("spi_ldac_n", i, 16'(ldac[i]),
            16'(!(acc_ok[i] && chn[i] && (m_t >= 32 * m_d) && (m_t < 34 * m_d))));
`endif
      post_rst[i] = 1'b0;
      if (rst[i]) begin
        acc_ok[i]   = 1'b0;
        rdy_at[i]   = cyc + 1;
        mlast[i]    = 1'b1;
        post_rst[i] = 1'b1;
      end else if (m_rdy && (v0[i] || v1[i])) begin
        m_g       = (v0[i] && v1[i]) ? !mlast[i] : v1[i];
        fr[i]     = {m_g, cfg[i], (m_g ? d1[i] : d0[i])};
        acc[i]    = cyc;
        acc_ok[i] = 1'b1;
        chn[i]    = m_g;
        mlast[i]  = m_g;
        rdy_at[i] = cyc + 1 + 32 * m_d + gap_of(i, m_g);
        if (m_g) take1[i]++; else take0[i]++;
        hs[i]++;
      end
    end
    check("wait_timeout", 0, 16'(wait_expired), 16'(0));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (take0[i] != seen0[i]) begin
          seen0[i] = take0[i];
          if (refresh) d0[i] = 12'($urandom);
          if (oneshot) v0[i] = 1'b0;
        end
        if (take1[i] != seen1[i]) begin
          seen1[i] = take1[i];
          if (refresh) d1[i] = 12'($urandom);
          if (oneshot) v1[i] = 1'b0;
        end
        if (rnd_cfg) cfg[i] = 3'($urandom);
        if (rnd_valid) begin
          v0[i] = 1'($urandom);
          v1[i] = 1'($urandom);
        end
      end
      if (rnd_rst1) rst[1] = ($urandom_range(0, 199) == 0);
    end
  endtask

  initial begin
    int h0, k;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; v0[i] = 1'b0; v1[i] = 1'b0;
      d0[i] = 12'h0; d1[i] = 12'h0; cfg[i] = 3'b000;
    end
    step(3);
    for (int i = 0; i < 2; i++) rst[i] = 1'b0;

    // Single request: one ch0 sample, expect frame 0x7ABC.
    oneshot = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d0[i] = 12'hABC; cfg[i] = 3'b111; v0[i] = 1'b1;
    end
    step(150);
    oneshot = 1'b0;

    // Contention with fixed data: grants must alternate.
    for (int i = 0; i < 2; i++) begin
      d0[i] = 12'h001; d1[i] = 12'h002; v0[i] = 1'b1; v1[i] = 1'b1;
    end
    step(4 * 131 + 10);

    // ch1 streaming with cfg/data churning while frames are in flight.
    refresh = 1'b1;
    rnd_cfg = 1'b1;
    for (int i = 0; i < 2; i++) v0[i] = 1'b0;
    step(3 * 131 + 10);

    // Reset about 40 cycles into a default-timing frame.
    for (int i = 0; i < 2; i++) v0[i] = 1'b1;
    h0 = hs[0];
    k = 0;
    while (hs[0] == h0 && k < 300) begin
      step(1);
      k++;
    end
    if (hs[0] == h0) wait_expired = 1'b1;
    step(39);
    rst[0] = 1'b1;
    step(1);
    rst[0] = 1'b0;
    step(300);

    // Random traffic, with occasional resets on the fast instance.
    rnd_valid = 1'b1;
    rnd_rst1  = 1'b1;
    step(1200);
    rnd_valid = 1'b0;
    rnd_rst1  = 1'b0;
    rst[1]    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0;
    end
    step(150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
